// File: rtl/tone_chk_pkg.sv
// Shared types and defaults for the tone half-period checker.
package tone_chk_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP    = 2'd1,
        COLLECT = 2'd2,
        REPORT  = 2'd3
    } state_t;

    localparam int CNT_W_DFLT  = 10;
    localparam int MAG_W_DFLT  = 8;
    localparam int LOG2_N_DFLT = 3;
    localparam int WARMUP_DFLT = 2;

    // Sum of 2**log2_n samples of cnt_w bits cannot overflow this width.
    function automatic int acc_width(input int cnt_w, input int log2_n);
        return cnt_w + log2_n;
    endfunction

endpackage

// File: rtl/tone_window_cmp.sv
// Combinational tolerance check: |sample - expected| <= tol, with one guard bit.
module tone_window_cmp #(
    parameter int CNT_W = 10
) (
    input  logic [CNT_W-1:0] sample,
    input  logic [CNT_W-1:0] expected,
    input  logic [3:0]       tol,
    output logic             in_window
);
    localparam int W = CNT_W + 1;

    logic [W-1:0] diff;

    always_comb begin
        if (sample >= expected) begin
            diff = {1'b0, sample} - {1'b0, expected};
        end else begin
            diff = {1'b0, expected} - {1'b0, sample};
        end
        in_window = (diff <= W'(tol));
    end

endmodule

// File: rtl/tone_period_checker.sv
// Collects a window of half-period measurements and reports avg/min/max/amplitude and a verdict.
// Optional watchdog enabled by defining TONE_CHK_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for start, results held
// SKIP    | discarding WARMUP leading measurements
// COLLECT | accumulating N window samples
// REPORT  | one cycle, result_valid pulse
module tone_period_checker
    import tone_chk_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DFLT,
    parameter int MAG_W  = MAG_W_DFLT,
    parameter int LOG2_N = LOG2_N_DFLT,
    parameter int WARMUP = WARMUP_DFLT
`ifdef TONE_CHK_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] expected_half,
    input  logic [3:0]       tolerance,
    input  logic [CNT_W-1:0] meas_counter,
    input  logic             meas_done,
    input  logic [MAG_W-1:0] meas_magnitude,
    output logic             busy,
    output logic             result_valid,
    output logic [CNT_W-1:0] avg_half,
    output logic [CNT_W-1:0] min_half,
    output logic [CNT_W-1:0] max_half,
    output logic [MAG_W-1:0] amplitude,
    output logic             pass,
    output logic             fail
);
    localparam int ACC_W  = acc_width(CNT_W, LOG2_N);
    localparam int SKIP_W = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((WARMUP > 0) ? WARMUP - 1 : 0);

    state_t state, state_nxt;

    logic [CNT_W-1:0]  exp_q;
    logic [3:0]        tol_q;
    logic [SKIP_W-1:0] skip_cnt;
    logic [LOG2_N-1:0] sample_cnt;
    logic [ACC_W-1:0]  acc, acc_upd;
    logic [CNT_W-1:0]  min_q, max_q, min_upd, max_upd;
    logic [MAG_W-1:0]  mag_min, mag_max, mag_min_upd, mag_max_upd;
    logic              err, err_upd, in_window;
    logic              take_start, strobe_col, last_sample, timeout_go, to_report;

    assign take_start  = (state == IDLE) && start;
    assign strobe_col  = (state == COLLECT) && meas_done;
    assign last_sample = strobe_col && (sample_cnt == '1);
    assign to_report   = last_sample || timeout_go;

    tone_window_cmp #(.CNT_W(CNT_W)) u_cmp (
        .sample    (meas_counter),
        .expected  (exp_q),
        .tol       (tol_q),
        .in_window (in_window)
    );

`ifdef TONE_CHK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    logic [WD_W-1:0] wd_cnt;

    // Down-counter reloaded on start and on every strobe; terminal count forces REPORT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if (take_start || (busy && meas_done)) begin
            wd_cnt <= WD_W'(TIMEOUT_CYC - 1);
        end else if (busy && (wd_cnt != '0)) begin
            wd_cnt <= wd_cnt - 1'b1;
        end
    end

    assign timeout_go = busy && !meas_done && (wd_cnt == '0);
`else
    assign timeout_go = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (WARMUP == 0) ? COLLECT : SKIP;
            SKIP: begin
                if (timeout_go)                                  state_nxt = REPORT;
                else if (meas_done && (skip_cnt == SKIP_LAST))   state_nxt = COLLECT;
            end
            COLLECT: if (to_report) state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state == SKIP) || (state == COLLECT);
        result_valid = (state == REPORT);
    end

    // Window statistics including the sample on this cycle, so REPORT shows the Nth sample.
    always_comb begin
        acc_upd     = acc;
        min_upd     = min_q;
        max_upd     = max_q;
        mag_min_upd = mag_min;
        mag_max_upd = mag_max;
        err_upd     = err;
        if (strobe_col) begin
            acc_upd = acc + ACC_W'(meas_counter);
            if (meas_counter < min_q)     min_upd     = meas_counter;
            if (meas_counter > max_q)     max_upd     = meas_counter;
            if (meas_magnitude < mag_min) mag_min_upd = meas_magnitude;
            if (meas_magnitude > mag_max) mag_max_upd = meas_magnitude;
            if (!in_window)               err_upd     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q      <= '0;
            tol_q      <= '0;
            skip_cnt   <= '0;
            sample_cnt <= '0;
            acc        <= '0;
            min_q      <= '0;
            max_q      <= '0;
            mag_min    <= '0;
            mag_max    <= '0;
            err        <= 1'b0;
            avg_half   <= '0;
            min_half   <= '0;
            max_half   <= '0;
            amplitude  <= '0;
            pass       <= 1'b0;
            fail       <= 1'b0;
        end else if (take_start) begin
            exp_q      <= expected_half;
            tol_q      <= tolerance;
            skip_cnt   <= '0;
            sample_cnt <= '0;
            acc        <= '0;
            min_q      <= '1;
            max_q      <= '0;
            mag_min    <= '1;
            mag_max    <= '0;
            err        <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            if ((state == SKIP) && meas_done) skip_cnt <= skip_cnt + 1'b1;
            if (strobe_col) begin
                sample_cnt <= sample_cnt + 1'b1;
                acc        <= acc_upd;
                min_q      <= min_upd;
                max_q      <= max_upd;
                mag_min    <= mag_min_upd;
                mag_max    <= mag_max_upd;
                err        <= err_upd;
            end
            if (to_report) begin
                avg_half  <= acc_upd[ACC_W-1:LOG2_N];
                min_half  <= min_upd;
                max_half  <= max_upd;
                amplitude <= (mag_max_upd >= mag_min_upd) ? (mag_max_upd - mag_min_upd) : '0;
                pass      <= !(err_upd || timeout_go);
                fail      <= err_upd || timeout_go;
            end
        end
    end

endmodule

// File: tb/tb_tone_period_checker.sv
// Directed table-driven bench for tone_period_checker plus hand-written corner sequences.
module tb_tone_period_checker;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [9:0] expected_half;
    logic [3:0] tolerance;
    logic [9:0] meas_counter;
    logic       meas_done;
    logic [7:0] meas_magnitude;
    logic       busy;
    logic       result_valid;
    logic [9:0] avg_half;
    logic [9:0] min_half;
    logic [9:0] max_half;
    logic [7:0] amplitude;
    logic       pass;
    logic       fail;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tone_period_checker dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .expected_half  (expected_half),
        .tolerance      (tolerance),
        .meas_counter   (meas_counter),
        .meas_done      (meas_done),
        .meas_magnitude (meas_magnitude),
        .busy           (busy),
        .result_valid   (result_valid),
        .avg_half       (avg_half),
        .min_half       (min_half),
        .max_half       (max_half),
        .amplitude      (amplitude),
        .pass           (pass),
        .fail           (fail)
    );

    typedef struct {
        logic [9:0] exp_h;
        logic [3:0] tol;
        logic [9:0] sa;
        logic [9:0] sb;
        int         out_idx;
        logic [9:0] out_val;
        logic [7:0] ma;
        logic [7:0] mb;
        logic [9:0] e_avg;
        logic [9:0] e_min;
        logic [9:0] e_max;
        logic [7:0] e_amp;
        logic       e_pass;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Called at a negedge; returns at the negedge after the capturing posedge.
    task automatic strobe(input logic [9:0] c, input logic [7:0] m);
        meas_counter   = c;
        meas_magnitude = m;
        meas_done      = 1'b1;
        @(negedge clk);
        meas_done      = 1'b0;
    endtask

    task automatic do_start(input logic [9:0] e, input logic [3:0] t);
        expected_half = e;
        tolerance     = t;
        start         = 1'b1;
        @(negedge clk);
        start         = 1'b0;
    endtask

    function automatic logic [9:0] samp(input vec_t v, input int i);
        if (i == v.out_idx) return v.out_val;
        return (i % 2 == 0) ? v.sa : v.sb;
    endfunction

    initial begin
        logic early;
        int   cyc;

        //             exp   tol sa    sb    idx val  ma     mb     avg   min   max   amp    pass
        vecs[0] = '{10'd100, 4'd0, 10'd100, 10'd100, -1, 10'd0,  8'h40, 8'h40, 10'd100, 10'd100, 10'd100, 8'h00, 1'b1};
        vecs[1] = '{10'd100, 4'd2, 10'd98,  10'd102, -1, 10'd0,  8'h0F, 8'hF0, 10'd100, 10'd98,  10'd102, 8'hE1, 1'b1};
        vecs[2] = '{10'd100, 4'd3, 10'd100, 10'd100,  5, 10'd105,8'h10, 8'h10, 10'd100, 10'd100, 10'd105, 8'h00, 1'b0};
        vecs[3] = '{10'd1,   4'd5, 10'd1,   10'd1,   -1, 10'd0,  8'h20, 8'h21, 10'd1,   10'd1,   10'd1,   8'h01, 1'b1};
        vecs[4] = '{10'd0,   4'd0, 10'd0,   10'd0,   -1, 10'd0,  8'h00, 8'hFF, 10'd0,   10'd0,   10'd0,   8'hFF, 1'b1};
        vecs[5] = '{10'd10,  4'd4, 10'd6,   10'd14,  -1, 10'd0,  8'h80, 8'h7F, 10'd10,  10'd6,   10'd14,  8'h01, 1'b1};
        vecs[6] = '{10'd10,  4'd4, 10'd10,  10'd10,   7, 10'd15, 8'h55, 8'h55, 10'd10,  10'd10,  10'd15,  8'h00, 1'b0};
        vecs[7] = '{10'd1023,4'd15,10'd1023,10'd1008,-1, 10'd0,  8'hFF, 8'h01, 10'd1015,10'd1008,10'd1023,8'hFE, 1'b1};
        vecs[8] = '{10'd3,   4'd5, 10'd3,   10'd3,    0, 10'd9,  8'h00, 8'h01, 10'd3,   10'd3,   10'd9,   8'h01, 1'b0};

        reset_n        = 1'b0;
        start          = 1'b0;
        expected_half  = '0;
        tolerance      = '0;
        meas_counter   = '0;
        meas_done      = 1'b0;
        meas_magnitude = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_rv", result_valid, 0);
        chk("reset_avg", avg_half, 0);
        chk("reset_min", min_half, 0);
        chk("reset_max", max_half, 0);
        chk("reset_amp", amplitude, 0);
        chk("reset_pass", pass, 0);
        chk("reset_fail", fail, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Strobe coincident with start is ignored; a second start while busy is ignored.
        expected_half  = 10'd100;
        tolerance      = 4'd0;
        start          = 1'b1;
        meas_counter   = 10'd77;
        meas_done      = 1'b1;
        @(negedge clk);
        start          = 1'b0;
        meas_done      = 1'b0;
        chk("seqA_busy", busy, 1);
        strobe(10'd500, 8'h00);
        @(negedge clk);
        do_start(10'd50, 4'd0);
        strobe(10'd7, 8'hFF);
        @(negedge clk);
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            strobe(10'd100, 8'h33);
            if (i < 7) begin
                early |= result_valid;
                @(negedge clk);
                early |= result_valid;
            end
        end
        chk("seqA_no_early", early, 0);
        chk("seqA_rv", result_valid, 1);
        chk("seqA_pass", pass, 1);
        chk("seqA_avg", avg_half, 100);
        chk("seqA_min", min_half, 100);
        chk("seqA_amp", amplitude, 0);
        @(negedge clk);
        chk("seqA_rv_pulse", result_valid, 0);
        repeat (3) @(negedge clk);
        chk("hold_avg", avg_half, 100);
        chk("hold_pass", pass, 1);

        // New start clears verdict but holds stats; then reset mid-COLLECT.
        do_start(10'd200, 4'd1);
        chk("restart_pass_clr", pass, 0);
        chk("restart_fail_clr", fail, 0);
        chk("restart_avg_held", avg_half, 100);
        strobe(10'd200, 8'h00); @(negedge clk);
        strobe(10'd200, 8'h00); @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            strobe(10'd200, 8'h10);
            @(negedge clk);
        end
        chk("mid_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_avg", avg_half, 0);
        chk("midrst_min", min_half, 0);
        chk("midrst_max", max_half, 0);
        chk("midrst_pass", pass, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            do_start(vecs[v].exp_h, vecs[v].tol);
            chk($sformatf("v%0d_busy", v), busy, 1);
            strobe(10'h3FF, 8'hFF); @(negedge clk);
            strobe(10'h000, 8'h00); @(negedge clk);
            early = 1'b0;
            for (int i = 0; i < 8; i++) begin
                strobe(samp(vecs[v], i), (i % 2 == 0) ? vecs[v].ma : vecs[v].mb);
                if (i < 7) begin
                    early |= result_valid;
                    @(negedge clk);
                    early |= result_valid;
                end
            end
            chk($sformatf("v%0d_no_early", v), early, 0);
            chk($sformatf("v%0d_rv", v), result_valid, 1);
            chk($sformatf("v%0d_avg", v), avg_half, vecs[v].e_avg);
            chk($sformatf("v%0d_min", v), min_half, vecs[v].e_min);
            chk($sformatf("v%0d_max", v), max_half, vecs[v].e_max);
            chk($sformatf("v%0d_amp", v), amplitude, vecs[v].e_amp);
            chk($sformatf("v%0d_pass", v), pass, vecs[v].e_pass);
            chk($sformatf("v%0d_fail", v), fail, !vecs[v].e_pass);
            @(negedge clk);
            chk($sformatf("v%0d_rv_drop", v), result_valid, 0);
            chk($sformatf("v%0d_idle", v), busy, 0);
        end

`ifdef TONE_CHK_TIMEOUT_EN
        do_start(10'd100, 4'd2);
        cyc = 0;
        while (!result_valid && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk("timeout_cycles", cyc, 4096);
        chk("timeout_fail", fail, 1);
        chk("timeout_pass", pass, 0);
`else
        cyc = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
